tile_fetch_sequencer: RTL and testbench

- Sequences all SRAM reads for one template-matching pass over a stored frame.
- Walks a range of sets. For each set it reads the search window region first, then the template window region.
- Generates the same linear word addresses as the team's address map and drives them to the frame memory read port with a valid/ready handshake.
- Tags every beat with frame/set/tem_win/row/col so the correlation datapath can steer data.

---
 rtl/tile_fetch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tile_fetch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_fetch_sequencer.sv
// Read-address sequencer for one template-matching pass over a stored frame.
// Walks sets first..last, issuing search-window beats then template beats.
module tile_fetch_sequencer #(
    parameter int SET_COUNT = 150,
    parameter int SET_WORDS = 1665,
    parameter int TEM_BASE  = 65,
    parameter int TEM_ROWS  = 80,
    parameter int TEM_COLS  = 20,
    parameter int WIN_ROWS  = 16,
    parameter int WIN_COLS  = 4,
    parameter int ADDR_W    = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              frame_in,
    input  logic [7:0]        first_set,
    input  logic [7:0]        last_set,
    input  logic              abort,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_tem_win,
    output logic [6:0]        rd_row,
    output logic [6:0]        rd_col,
    output logic [7:0]        rd_set,
    output logic              rd_frame,
    output logic              set_done,
    output logic              done,
    output logic              start_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] FRAME_BASE = ADDR_W'(SET_COUNT * SET_WORDS);
    localparam logic [ADDR_W-1:0] SET_STEP   = ADDR_W'(SET_WORDS);
    localparam logic [ADDR_W-1:0] TEM_OFS    = ADDR_W'(TEM_BASE);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [7:0]        SET_MAX    = 8'(SET_COUNT - 1);
    localparam logic [6:0]        WIN_ROW_END = 7'(WIN_ROWS - 1);
    localparam logic [6:0]        WIN_COL_END = 7'(WIN_COLS - 1);
    localparam logic [6:0]        TEM_ROW_END = 7'(TEM_ROWS - 1);
    localparam logic [6:0]        TEM_COL_END = 7'(TEM_COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WIN,
        TEM,
        SET_END,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] set_base;
    logic [7:0]        last_r;

    logic              xfer;
    logic              start_ok;
    logic              col_end;
    logic              row_end;
    logic [ADDR_W-1:0] start_base;

    assign xfer     = rd_valid && rd_ready;
    assign start_ok = (first_set <= last_set) && (last_set <= SET_MAX);
    assign col_end  = rd_col == (rd_tem_win ? TEM_COL_END : WIN_COL_END);
    assign row_end  = rd_row == (rd_tem_win ? TEM_ROW_END : WIN_ROW_END);

    // Constant multiply only on the start path; beats step incrementally.
    assign start_base = (frame_in ? FRAME_BASE : '0)
                      + ADDR_W'(first_set) * SET_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            set_base   <= '0;
            last_r     <= '0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            rd_tem_win <= 1'b0;
            rd_row     <= '0;
            rd_col     <= '0;
            rd_set     <= '0;
            rd_frame   <= 1'b0;
            set_done   <= 1'b0;
            done       <= 1'b0;
            start_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            set_done  <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                rd_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && start_ok) begin
                            state      <= WIN;
                            set_base   <= start_base;
                            rd_addr    <= start_base;
                            last_r     <= last_set;
                            rd_set     <= first_set;
                            rd_frame   <= frame_in;
                            rd_row     <= '0;
                            rd_col     <= '0;
                            rd_tem_win <= 1'b0;
                            rd_valid   <= 1'b1;
                            busy       <= 1'b1;
                        end else if (start) begin
                            start_err <= 1'b1;
                        end
                    end
                    WIN, TEM: begin
                        if (xfer) begin
                            if (!col_end) begin
                                rd_col  <= rd_col + 7'd1;
                                rd_addr <= rd_addr + ONE;
                            end else if (!row_end) begin
                                rd_col  <= '0;
                                rd_row  <= rd_row + 7'd1;
                                rd_addr <= rd_addr + ONE;
                            end else if (state == WIN) begin
                                // Word between regions is skipped.
                                state      <= TEM;
                                rd_col     <= '0;
                                rd_row     <= '0;
                                rd_tem_win <= 1'b1;
                                rd_addr    <= set_base + TEM_OFS;
                            end else begin
                                state    <= SET_END;
                                rd_valid <= 1'b0;
                                set_done <= 1'b1;
                            end
                        end
                    end
                    SET_END: begin
                        if (rd_set == last_r) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= WIN;
                            rd_set     <= rd_set + 8'd1;
                            set_base   <= set_base + SET_STEP;
                            rd_addr    <= set_base + SET_STEP;
                            rd_row     <= '0;
                            rd_col     <= '0;
                            rd_tem_win <= 1'b0;
                            rd_valid   <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        rd_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// Bench for tile_fetch_sequencer: pass table plus abort/reset sequences.
// Beat scoreboard filled from the address-map formula.
module tb_tile_fetch_sequencer;

    localparam int SET_COUNT = 150;
    localparam int SET_WORDS = 1665;
    localparam int TEM_BASE  = 65;
    localparam int TEM_ROWS  = 80;
    localparam int TEM_COLS  = 20;
    localparam int WIN_ROWS  = 16;
    localparam int WIN_COLS  = 4;
    localparam int ADDR_W    = 21;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              frame_in;
    logic [7:0]        first_set;
    logic [7:0]        last_set;
    logic              abort;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_tem_win;
    logic [6:0]        rd_row;
    logic [6:0]        rd_col;
    logic [7:0]        rd_set;
    logic              rd_frame;
    logic              set_done;
    logic              done;
    logic              start_err;
    logic              busy;

    tile_fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_in   (frame_in),
        .first_set  (first_set),
        .last_set   (last_set),
        .abort      (abort),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_tem_win (rd_tem_win),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_set     (rd_set),
        .rd_frame   (rd_frame),
        .set_done   (set_done),
        .done       (done),
        .start_err  (start_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [20:0] addr;
        logic        tw;
        logic [6:0]  row;
        logic [6:0]  col;
        logic [7:0]  set;
        logic        frame;
    } beat_t;

    typedef struct {
        logic        frame;
        logic [7:0]  first;
        logic [7:0]  last;
        bit          rnd;
        bit          err;
        int          beats;
        int          sdones;
        int          a_first;
        int          a_tem;
        int          a_last;
    } vec_t;

    beat_t       sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          beat_cnt = 0;
    int          sd_cnt = 0;
    int          done_cnt = 0;
    int          first_addr = 0;
    int          first_tem = 0;
    int          last_addr = 0;
    bit          seen_tem = 0;
    bit          pend_sd = 0;
    bit          prev_stall = 0;
    beat_t       prev;
    vec_t        vecs[5];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic push_pass(input int f, input int s0, input int s1);
        beat_t b;
        for (int s = s0; s <= s1; s++) begin
            for (int r = 0; r < WIN_ROWS; r++)
                for (int c = 0; c < WIN_COLS; c++) begin
                    b.addr  = 21'(f * SET_COUNT * SET_WORDS + s * SET_WORDS
                                  + r * WIN_COLS + c);
                    b.tw    = 1'b0;
                    b.row   = 7'(r);
                    b.col   = 7'(c);
                    b.set   = 8'(s);
                    b.frame = 1'(f);
                    sbq.push_back(b);
                end
            for (int r = 0; r < TEM_ROWS; r++)
                for (int c = 0; c < TEM_COLS; c++) begin
                    b.addr  = 21'(f * SET_COUNT * SET_WORDS + s * SET_WORDS
                                  + TEM_BASE + r * TEM_COLS + c);
                    b.tw    = 1'b1;
                    b.row   = 7'(r);
                    b.col   = 7'(c);
                    b.set   = 8'(s);
                    b.frame = 1'(f);
                    sbq.push_back(b);
                end
        end
    endtask

    task automatic clear_counts();
        sbq.delete();
        beat_cnt   = 0;
        sd_cnt     = 0;
        done_cnt   = 0;
        first_addr = 0;
        first_tem  = 0;
        last_addr  = 0;
        seen_tem   = 0;
    endtask

    always @(negedge clk) begin
        beat_t b;
        beat_t e;
        b = {rd_addr, rd_tem_win, rd_row, rd_col, rd_set, rd_frame};
        if (pend_sd) begin
            checks++;
            if (!(set_done && !rd_valid)) begin
                errors++;
                $display("FAIL set_done_after_last got sd=%0b vld=%0b want sd=1 vld=0",
                         set_done, rd_valid);
            end
            pend_sd = 0;
        end
        if (prev_stall && rd_valid) begin
            checks++;
            if (b !== prev) begin
                errors++;
                $display("FAIL stall_hold got=%h want=%h", b, prev);
            end
        end
        if (set_done) sd_cnt++;
        if (done) done_cnt++;
        if (rd_valid && rd_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL beat_extra got addr=%0d want none", rd_addr);
            end else begin
                e = sbq.pop_front();
                if (b !== e) begin
                    errors++;
                    $display("FAIL beat_%0d got a=%0d t=%0b r=%0d c=%0d s=%0d f=%0b want a=%0d t=%0b r=%0d c=%0d s=%0d f=%0b",
                             beat_cnt, b.addr, b.tw, b.row, b.col, b.set, b.frame,
                             e.addr, e.tw, e.row, e.col, e.set, e.frame);
                end
            end
            if (beat_cnt == 0) first_addr = int'(rd_addr);
            if (rd_tem_win && !seen_tem) begin
                first_tem = int'(rd_addr);
                seen_tem  = 1;
            end
            last_addr = int'(rd_addr);
            beat_cnt++;
            if (rd_tem_win && rd_row == 7'(TEM_ROWS - 1)
                && rd_col == 7'(TEM_COLS - 1))
                pend_sd = 1;
        end
        prev_stall = rd_valid && !rd_ready;
        prev = b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        clear_counts();
        if (!v.err) push_pass(int'(v.frame), int'(v.first), int'(v.last));
        frame_in  = v.frame;
        first_set = v.first;
        last_set  = v.last;
        rd_ready  = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        if (v.err) begin
            chk("start_err_pulse", start_err, 1);
            chk("err_busy", busy, 0);
            repeat (5) step();
            chk("err_no_beats", beat_cnt, 0);
            chk("err_busy_after", busy, 0);
            chk("err_pulse_once", start_err, 0);
        end else begin
            chk("start_busy", busy, 1);
            chk("start_valid", rd_valid, 1);
            for (int c = 0; c < 30000 && done_cnt == 0; c++) begin
                rd_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                step();
            end
            rd_ready = 1'b1;
            chk("done_pulses", done_cnt, 1);
            chk("beat_count", beat_cnt, v.beats);
            chk("set_done_count", sd_cnt, v.sdones);
            chk("first_addr", first_addr, v.a_first);
            chk("first_tem_addr", first_tem, v.a_tem);
            chk("last_addr", last_addr, v.a_last);
            chk("queue_empty", sbq.size(), 0);
            chk("idle_busy", busy, 0);
        end
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        frame_in  = 1'b0;
        first_set = '0;
        last_set  = '0;
        abort     = 1'b0;
        rd_ready  = 1'b0;

        vecs[0] = '{1'b0, 8'd0,   8'd0,   0, 0, 1664, 1, 0,      65,     1664};
        vecs[1] = '{1'b1, 8'd149, 8'd149, 0, 0, 1664, 1, 497835, 497900, 499499};
        vecs[2] = '{1'b0, 8'd3,   8'd5,   1, 0, 4992, 3, 4995,   5060,   9989};
        vecs[3] = '{1'b0, 8'd5,   8'd3,   0, 1, 0,    0, 0,      0,      0};
        vecs[4] = '{1'b0, 8'd0,   8'd150, 0, 1, 0,    0, 0,      0,      0};

        repeat (3) step();
        chk("reset_outputs",
            {rd_valid, rd_addr, rd_tem_win, rd_row, rd_col, rd_set,
             rd_frame, set_done, done, start_err, busy}, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort on template beat 100 of set 2.
        clear_counts();
        push_pass(0, 2, 3);
        frame_in  = 1'b0;
        first_set = 8'd2;
        last_set  = 8'd3;
        rd_ready  = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 400 && beat_cnt != 164; c++) step();
        chk("abort_reach", beat_cnt, 164);
        chk("abort_beat_tem", {rd_tem_win, rd_row, rd_col}, {1'b1, 7'd5, 7'd0});
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", rd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_beat_counted", beat_cnt, 165);
        repeat (4) step();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_set_done", sd_cnt, 0);
        chk("abort_stays_idle", {busy, rd_valid}, 0);
        run_vec(vecs[0]);

        // Reset in the middle of the search window.
        clear_counts();
        push_pass(1, 7, 7);
        frame_in  = 1'b1;
        first_set = 8'd7;
        last_set  = 8'd7;
        rd_ready  = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("pre_reset_win", {busy, rd_valid, rd_tem_win}, 3'b110);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs",
            {rd_valid, rd_addr, rd_tem_win, rd_row, rd_col, rd_set,
             rd_frame, set_done, done, start_err, busy}, 0);
        sbq.delete();
        repeat (3) step();
        rst_n = 1'b1;
        beat_cnt = 0;
        repeat (6) step();
        chk("post_reset_idle", {busy, rd_valid}, 0);
        chk("post_reset_no_beats", beat_cnt, 0);
        chk("post_reset_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
